uart_program_loader: RTL



---
 rtl/uart_program_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// UART program loader: receives a length-prefixed program image over 8N1 serial
// and writes it word by word into instruction RAM while holding the CPU in reset.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12,
  parameter int MAX_WORDS    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]       MAX_N    = 17'(MAX_WORDS);
  localparam logic [ADDR_W:0]   ONE_W    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN1, L_WORD, L_DONE, L_ERR} ld_state_t;

  logic             rx_meta, rx_sync;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             byte_valid, framing_err;

  ld_state_t        ld_state;
  logic [7:0]       n_lo;
  logic [ADDR_W:0]  n_count;
  logic [ADDR_W-1:0] addr;
  logic [1:0]       byte_idx;
  logic [31:0]      word;
  logic [15:0]      len_full;
  logic [31:0]      word_next;

  assign len_full  = {rx_shift, n_lo};
  assign word_next = {rx_shift, word[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // Start bit is re-checked at mid-bit so short low glitches are rejected;
  // every later sample is one full bit period after the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == HALF_BIT) begin
            clk_cnt  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == FULL_BIT) begin
            clk_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == FULL_BIT) begin
            clk_cnt <= '0;
            if (rx_sync) byte_valid  <= 1'b1;
            else         framing_err <= 1'b1;
            rx_state <= RX_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader: 16-bit little-endian word count, then little-endian 32-bit words.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state     <= L_IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      n_lo         <= '0;
      n_count      <= '0;
      addr         <= '0;
      byte_idx     <= '0;
      word         <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (ld_state)
        L_IDLE: begin
          if (byte_valid) begin
            n_lo         <= rx_shift;
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
            ld_state     <= L_LEN1;
          end
        end
        L_LEN1: begin
          if (framing_err) begin
            error    <= 1'b1;
            ld_state <= L_ERR;
          end else if (byte_valid) begin
            if (len_full == 16'd0) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              ld_state <= L_IDLE;
            end else if ({1'b0, len_full} > MAX_N) begin
              error    <= 1'b1;
              ld_state <= L_ERR;
            end else begin
              n_count  <= len_full[ADDR_W:0];
              addr     <= '0;
              byte_idx <= '0;
              ld_state <= L_WORD;
            end
          end
        end
        L_WORD: begin
          if (framing_err) begin
            error    <= 1'b1;
            ld_state <= L_ERR;
          end else if (byte_valid) begin
            word     <= word_next;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= addr;
              mem_wdata    <= word_next;
              addr         <= addr + ONE_A;
              words_loaded <= words_loaded + ONE_W;
              if (words_loaded + ONE_W == n_count) ld_state <= L_DONE;
            end
          end
        end
        L_DONE: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
          ld_state <= L_IDLE;
        end
        L_ERR: begin
          error    <= 1'b1;
          cpu_hold <= 1'b1;
        end
        default: ld_state <= L_IDLE;
      endcase
    end
  end

endmodule
